// File: rtl/sm_arith_pkg.sv
// Shared sign-magnitude arithmetic definitions for the ALU and the sequential divider.
package sm_arith_pkg;

  // Sign bit encoding used by every sign-magnitude operand and result.
  localparam logic SIGN_POS = 1'b0;
  localparam logic SIGN_NEG = 1'b1;

  // Default operand widths shared with the ALU multiply path.
  localparam int unsigned DEF_DW = 8;
  localparam int unsigned DEF_VW = 4;

  // Divider control states.
  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StCalc = 1'b1
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division stage: shift in the next dividend bit, trial-subtract
// the divisor at VW+1 bits and keep the difference only when it did not go negative.
module div_step #(
  parameter int unsigned VW = 4
) (
  input  logic [VW-1:0] i_rem,
  input  logic          i_bit,
  input  logic [VW-1:0] i_divisor,
  output logic [VW-1:0] o_rem,
  output logic          o_qbit
);

  logic [VW:0] w_shift;
  logic [VW:0] w_diff;

  // Trial subtraction; the difference's MSB is the borrow, so a clear MSB means shift >= divisor.
  // The incoming remainder is always below the divisor, so the difference fits in VW+1 signed bits.
  always_comb begin
    w_shift = {i_rem, i_bit};
    w_diff  = w_shift - {1'b0, i_divisor};
    o_qbit  = ~w_diff[VW];
    o_rem   = o_qbit ? w_diff[VW-1:0] : w_shift[VW-1:0];
  end

endmodule

// File: rtl/sm_seq_divider.sv
// Sequential sign-magnitude restoring divider: one quotient bit per clock with a
// start/busy/done handshake. Magnitudes divide unsigned; signs are resolved at completion.
module sm_seq_divider
  import sm_arith_pkg::*;
#(
  parameter int unsigned DW = DEF_DW,
  parameter int unsigned VW = DEF_VW
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  input  logic [DW-1:0] i_dividend,
  input  logic          i_signa,
  input  logic [VW-1:0] i_divisor,
  input  logic          i_signb,
  output logic [DW-1:0] o_quotient,
  output logic          o_signq,
  output logic [VW-1:0] o_remainder,
  output logic          o_signr,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_div_zero
);

  localparam int unsigned CW = $clog2(DW + 1);

  div_state_e    r_state, w_state_nxt;
  logic [DW-1:0] r_dvd, w_dvd_nxt;      // dividend bits still to consume; quotient fills from LSB
  logic [VW-1:0] r_dvs, w_dvs_nxt;
  logic          r_signa, w_signa_nxt;
  logic          r_signb, w_signb_nxt;
  logic [VW-1:0] r_rem, w_rem_nxt;      // partial remainder
  logic [CW-1:0] r_count, w_count_nxt;
  logic [DW-1:0] r_quotient, w_quotient_nxt;
  logic          r_signq, w_signq_nxt;
  logic [VW-1:0] r_remainder, w_remainder_nxt;
  logic          r_signr, w_signr_nxt;
  logic          r_done, w_done_nxt;
  logic          r_div_zero, w_div_zero_nxt;

  logic [VW-1:0] w_step_rem;
  logic          w_step_qbit;
  logic [DW-1:0] w_dvd_shift;

  div_step #(
    .VW(VW)
  ) u_div_step (
    .i_rem    (r_rem),
    .i_bit    (r_dvd[DW-1]),
    .i_divisor(r_dvs),
    .o_rem    (w_step_rem),
    .o_qbit   (w_step_qbit)
  );

  assign w_dvd_shift = {r_dvd[DW-2:0], w_step_qbit};

  // State and datapath registers; reset aborts any operation without a done pulse.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= StIdle;
      r_dvd       <= '0;
      r_dvs       <= '0;
      r_signa     <= SIGN_POS;
      r_signb     <= SIGN_POS;
      r_rem       <= '0;
      r_count     <= '0;
      r_quotient  <= '0;
      r_signq     <= SIGN_POS;
      r_remainder <= '0;
      r_signr     <= SIGN_POS;
      r_done      <= 1'b0;
      r_div_zero  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_dvd       <= w_dvd_nxt;
      r_dvs       <= w_dvs_nxt;
      r_signa     <= w_signa_nxt;
      r_signb     <= w_signb_nxt;
      r_rem       <= w_rem_nxt;
      r_count     <= w_count_nxt;
      r_quotient  <= w_quotient_nxt;
      r_signq     <= w_signq_nxt;
      r_remainder <= w_remainder_nxt;
      r_signr     <= w_signr_nxt;
      r_done      <= w_done_nxt;
      r_div_zero  <= w_div_zero_nxt;
    end
  end

  // Next-state logic: latch on start in idle, iterate in calc, publish results on the last step.
  always_comb begin
    w_state_nxt     = r_state;
    w_dvd_nxt       = r_dvd;
    w_dvs_nxt       = r_dvs;
    w_signa_nxt     = r_signa;
    w_signb_nxt     = r_signb;
    w_rem_nxt       = r_rem;
    w_count_nxt     = r_count;
    w_quotient_nxt  = r_quotient;
    w_signq_nxt     = r_signq;
    w_remainder_nxt = r_remainder;
    w_signr_nxt     = r_signr;
    w_done_nxt      = 1'b0;
    w_div_zero_nxt  = r_div_zero;

    unique case (r_state)
      StIdle: begin
        if (i_start) begin
          w_dvd_nxt      = i_dividend;
          w_dvs_nxt      = i_divisor;
          w_signa_nxt    = i_signa;
          w_signb_nxt    = i_signb;
          w_rem_nxt      = '0;
          w_count_nxt    = '0;
          w_div_zero_nxt = 1'b0;
          w_state_nxt    = StCalc;
        end
      end
      StCalc: begin
        if (r_dvs == '0) begin
          // Zero divisor completes after a single cycle with all-zero results.
          w_quotient_nxt  = '0;
          w_signq_nxt     = SIGN_POS;
          w_remainder_nxt = '0;
          w_signr_nxt     = SIGN_POS;
          w_done_nxt      = 1'b1;
          w_div_zero_nxt  = 1'b1;
          w_state_nxt     = StIdle;
        end else begin
          w_rem_nxt   = w_step_rem;
          w_dvd_nxt   = w_dvd_shift;
          w_count_nxt = r_count + 1'b1;
          if (r_count == CW'(DW - 1)) begin
            // Truncating division: zero magnitudes always carry a positive sign.
            w_quotient_nxt  = w_dvd_shift;
            w_signq_nxt     = ((r_signa ^ r_signb) == SIGN_NEG && w_dvd_shift != '0) ?
                              SIGN_NEG : SIGN_POS;
            w_remainder_nxt = w_step_rem;
            w_signr_nxt     = (r_signa == SIGN_NEG && w_step_rem != '0) ? SIGN_NEG : SIGN_POS;
            w_done_nxt      = 1'b1;
            w_state_nxt     = StIdle;
          end
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  assign o_quotient  = r_quotient;
  assign o_signq     = r_signq;
  assign o_remainder = r_remainder;
  assign o_signr     = r_signr;
  assign o_busy      = (r_state == StCalc);
  assign o_done      = r_done;
  assign o_div_zero  = r_div_zero;

endmodule

// File: tb/tb_sm_seq_divider.sv
// Self-checking bench for sm_seq_divider: directed table, multi-cycle corner sequences and
// randomized operations checked against an arithmetic reference model.
module tb_sm_seq_divider;

  logic       i_clk;
  logic       i_rst;
  logic       i_start;
  logic [7:0] i_dividend;
  logic       i_signa;
  logic [3:0] i_divisor;
  logic       i_signb;
  logic [7:0] o_quotient;
  logic       o_signq;
  logic [3:0] o_remainder;
  logic       o_signr;
  logic       o_busy;
  logic       o_done;
  logic       o_div_zero;

  int checks = 0;
  int errors = 0;

  sm_seq_divider #(
    .DW(8),
    .VW(4)
  ) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_start    (i_start),
    .i_dividend (i_dividend),
    .i_signa    (i_signa),
    .i_divisor  (i_divisor),
    .i_signb    (i_signb),
    .o_quotient (o_quotient),
    .o_signq    (o_signq),
    .o_remainder(o_remainder),
    .o_signr    (o_signr),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_div_zero (o_div_zero)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int a;
    int sa;
    int b;
    int sb;
    int q;
    int sq;
    int r;
    int sr;
    int dz;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Truncating sign-magnitude division from plain integer arithmetic.
  function automatic void ref_div(input int a, input int sa, input int b, input int sb,
                                  output int q, output int sq, output int r, output int sr,
                                  output int dz);
    if (b == 0) begin
      q = 0; sq = 0; r = 0; sr = 0; dz = 1;
    end else begin
      q  = a / b;
      r  = a % b;
      sq = (q != 0) ? (sa ^ sb) : 0;
      sr = (r != 0) ? sa : 0;
      dz = 0;
    end
  endfunction

  // Issue a start from the current (off-edge) time, scramble operands once accepted, and wait
  // for done. Returns with time #1 after the done edge.
  task automatic do_op(input int a, input int sa, input int b, input int sb,
                       output int lat, output int busy_cyc, output int dz_at_start);
    i_start    = 1'b1;
    i_dividend = 8'(a);
    i_signa    = sa[0];
    i_divisor  = 4'(b);
    i_signb    = sb[0];
    @(posedge i_clk);
    #1;
    i_start     = 1'b0;
    i_dividend  = 8'($urandom);
    i_divisor   = 4'($urandom);
    i_signa     = 1'($urandom);
    i_signb     = 1'($urandom);
    dz_at_start = int'(o_div_zero);
    lat         = -1;
    busy_cyc    = 0;
    for (int n = 0; n <= 20; n++) begin
      if (o_done) begin
        lat = n;
        break;
      end
      if (o_busy) busy_cyc++;
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic chk_results(input string tag, input int q, input int sq, input int r,
                             input int sr, input int dz);
    chk({tag, ".q"}, int'(o_quotient), q);
    chk({tag, ".signq"}, int'(o_signq), sq);
    chk({tag, ".r"}, int'(o_remainder), r);
    chk({tag, ".signr"}, int'(o_signr), sr);
    chk({tag, ".div_zero"}, int'(o_div_zero), dz);
  endtask

  initial begin
    int lat, bc, dz0;
    int q, sq, r, sr, dz;
    int a, sa, b, sb;
    int saw_done;

    tbl[0] = '{a: 100, sa: 0, b: 7,  sb: 0, q: 14, sq: 0, r: 2, sr: 0, dz: 0};
    tbl[1] = '{a: 100, sa: 1, b: 7,  sb: 0, q: 14, sq: 1, r: 2, sr: 1, dz: 0};
    tbl[2] = '{a: 45,  sa: 0, b: 9,  sb: 1, q: 5,  sq: 1, r: 0, sr: 0, dz: 0};
    tbl[3] = '{a: 3,   sa: 1, b: 5,  sb: 0, q: 0,  sq: 0, r: 3, sr: 1, dz: 0};
    tbl[4] = '{a: 255, sa: 0, b: 0,  sb: 0, q: 0,  sq: 0, r: 0, sr: 0, dz: 1};
    tbl[5] = '{a: 255, sa: 1, b: 15, sb: 1, q: 17, sq: 0, r: 0, sr: 0, dz: 0};
    tbl[6] = '{a: 7,   sa: 0, b: 15, sb: 1, q: 0,  sq: 0, r: 7, sr: 0, dz: 0};
    tbl[7] = '{a: 255, sa: 1, b: 1,  sb: 0, q: 255, sq: 1, r: 0, sr: 0, dz: 0};

    i_rst = 1'b1; i_start = 1'b0; i_dividend = '0; i_signa = 1'b0;
    i_divisor = '0; i_signb = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    chk("reset.busy", int'(o_busy), 0);
    chk("reset.done", int'(o_done), 0);
    chk_results("reset", 0, 0, 0, 0, 0);
    i_rst = 1'b0;
    @(posedge i_clk);
    #1;

    // Directed table.
    foreach (tbl[i]) begin
      do_op(tbl[i].a, tbl[i].sa, tbl[i].b, tbl[i].sb, lat, bc, dz0);
      chk($sformatf("tbl%0d.latency", i), lat, (tbl[i].b == 0) ? 1 : 8);
      chk($sformatf("tbl%0d.busy_cycles", i), bc, (tbl[i].b == 0) ? 1 : 8);
      chk($sformatf("tbl%0d.dz_cleared", i), dz0, 0);
      chk_results($sformatf("tbl%0d", i), tbl[i].q, tbl[i].sq, tbl[i].r, tbl[i].sr, tbl[i].dz);
      @(posedge i_clk);
      #1;
      chk($sformatf("tbl%0d.done_pulse", i), int'(o_done), 0);
      chk($sformatf("tbl%0d.q_hold", i), int'(o_quotient), tbl[i].q);
    end

    // Start re-pulsed mid-operation must be ignored.
    i_start = 1'b1; i_dividend = 8'd225; i_signa = 1'b0; i_divisor = 4'd15; i_signb = 1'b0;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    repeat (3) begin
      @(posedge i_clk);
      #1;
    end
    i_start = 1'b1; i_dividend = 8'd9; i_divisor = 4'd3; i_signb = 1'b1;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    lat = -1;
    for (int n = 4; n <= 20; n++) begin
      if (o_done) begin
        lat = n;
        break;
      end
      @(posedge i_clk);
      #1;
    end
    chk("restart.latency", lat, 8);
    chk_results("restart", 15, 0, 0, 0, 0);

    // Back-to-back: start issued in the done cycle.
    do_op(50, 0, 4, 1, lat, bc, dz0);
    chk("b2b.latency", lat, 8);
    chk_results("b2b", 12, 1, 2, 0, 0);

    // Reset mid-operation aborts with no done.
    i_start = 1'b1; i_dividend = 8'd200; i_signa = 1'b1; i_divisor = 4'd6; i_signb = 1'b0;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    repeat (4) begin
      @(posedge i_clk);
      #1;
    end
    i_rst = 1'b1;
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    chk("abort.busy", int'(o_busy), 0);
    chk("abort.done", int'(o_done), 0);
    chk_results("abort", 0, 0, 0, 0, 0);
    saw_done = 0;
    repeat (10) begin
      @(posedge i_clk);
      #1;
      if (o_done) saw_done = 1;
    end
    chk("abort.no_done", saw_done, 0);
    do_op(200, 0, 6, 0, lat, bc, dz0);
    chk("after_abort.latency", lat, 8);
    chk_results("after_abort", 33, 0, 2, 0, 0);

    // Randomized operations against the reference model.
    for (int k = 0; k < 60; k++) begin
      a  = int'($urandom_range(255, 0));
      sa = int'($urandom_range(1, 0));
      b  = (k % 10 == 3) ? 0 : int'($urandom_range(15, 0));
      sb = int'($urandom_range(1, 0));
      ref_div(a, sa, b, sb, q, sq, r, sr, dz);
      do_op(a, sa, b, sb, lat, bc, dz0);
      chk($sformatf("rnd%0d.latency(%0d/%0d)", k, a, b), lat, (b == 0) ? 1 : 8);
      chk_results($sformatf("rnd%0d(%0d/%0d)", k, a, b), q, sq, r, sr, dz);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
